// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {StBlank, StShow} state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-slot blanking interval.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                segments_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digits_out,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

  localparam int unsigned IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL        = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_q, en_q;
  logic [PRE_W-1:0]        pre_q;
  logic [IDX_W-1:0]        idx_q, idx_next, sel_idx;
  state_t                  state_q;
  logic                    wrap, enter_show;
  logic [3:0]              sel_nib;
  logic                    sel_dp, sel_en, sel_lz;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              nib_q;
  logic                    seg_on_q, dp_on_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [6:0]              seg_dec;
`ifdef SEG7_LZ_SUPPRESS_EN
  logic                    higher_zero;
`endif

  assign wrap     = (pre_q == PRE_LAST);
  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // With no blanking interval the wrap edge must latch the upcoming digit directly.
  always_comb begin
    enter_show = 1'b0;
    sel_idx    = idx_q;
    unique case (state_q)
      StBlank: enter_show = (pre_q == BLANK_LAST);
      StShow: begin
        if (wrap && BLANK_CYCLES == 0) begin
          enter_show = 1'b1;
          sel_idx    = idx_next;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_nib    = '0;
    sel_dp     = 1'b0;
    sel_en     = 1'b0;
    sel_lz     = 1'b0;
    sel_onehot = '0;
`ifdef SEG7_LZ_SUPPRESS_EN
    higher_zero = 1'b1;
`endif
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_nib       = data_q[4*k +: 4];
        sel_dp        = dp_q[k];
        sel_en        = en_q[k];
        sel_onehot[k] = 1'b1;
`ifdef SEG7_LZ_SUPPRESS_EN
        sel_lz = (k != 0) && higher_zero && (data_q[4*k +: 4] == 4'h0);
`endif
      end
`ifdef SEG7_LZ_SUPPRESS_EN
      if (data_q[4*k +: 4] != 4'h0 && en_q[k]) higher_zero = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      en_q     <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      state_q  <= StBlank;
      nib_q    <= '0;
      seg_on_q <= 1'b0;
      dp_on_q  <= 1'b0;
      dig_q    <= '0;
    end else begin
      if (load) begin
        data_q <= data_in;
        dp_q   <= dp_in;
        en_q   <= digit_en;
      end
      if (wrap) begin
        pre_q <= '0;
        idx_q <= idx_next;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      if (enter_show) begin
        state_q  <= StShow;
        nib_q    <= sel_nib;
        seg_on_q <= sel_en & ~sel_lz;
        dp_on_q  <= sel_en & sel_dp;
        // A suppressed zero keeps its digit selected only to light a set dp.
        dig_q    <= (sel_en & (~sel_lz | sel_dp)) ? sel_onehot : '0;
      end else if (state_q == StShow && wrap) begin
        state_q  <= StBlank;
        seg_on_q <= 1'b0;
        dp_on_q  <= 1'b0;
        dig_q    <= '0;
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex (nib_q),
    .seg (seg_dec)
  );

  assign segments_out = (seg_on_q ? seg_dec : 7'h00) ^ {7{POL}};
  assign dp_out       = dp_on_q ^ POL;
  assign digits_out   = dig_q ^ {NUM_DIGITS{POL}};
  assign scan_idx     = idx_q;

endmodule
